// File: rtl/mmu_pkg.sv
// Shared constants and types for the MMU memory responder: MMIO register
// offsets, PTE/CTRL bit positions and the page-table entry layout.
package mmu_pkg;

  localparam logic [5:0] OFF_PTE_BASE   = 6'h00;
  localparam logic [5:0] OFF_CTRL       = 6'h20;
  localparam logic [5:0] OFF_FAULT_ADDR = 6'h22;

  localparam int unsigned PTE_V   = 15;
  localparam int unsigned PTE_W   = 14;
  localparam int unsigned CTRL_EN = 0;

  // Frame number occupies the low bits of body; remaining body bits are stored but unused.
  typedef struct packed {
    logic        valid;
    logic        writable;
    logic [13:0] body;
  } pte_t;

endpackage

// File: rtl/mmu_pte_file.sv
// 16-entry page table: one write port, a translation read port that yields
// {valid, writable, frame} for a page, and a raw read port for MMIO.
module mmu_pte_file
  import mmu_pkg::*;
#(
  parameter int unsigned FRAME_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_we,
  input  logic [3:0]         i_widx,
  input  logic [15:0]        i_wdata,
  input  logic [3:0]         i_tidx,
  output logic               o_tvalid,
  output logic               o_twritable,
  output logic [FRAME_W-1:0] o_tframe,
  input  logic [3:0]         i_ridx,
  output logic [15:0]        o_rdata
);

  pte_t r_pte [16];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 16; i++) begin
        r_pte[i] <= '0;
      end
    end else if (i_we) begin
      r_pte[i_widx] <= pte_t'(i_wdata);
    end
  end

  assign o_tvalid    = r_pte[i_tidx].valid;
  assign o_twritable = r_pte[i_tidx].writable;
  assign o_tframe    = r_pte[i_tidx].body[FRAME_W-1:0];
  assign o_rdata     = r_pte[i_ridx];

endmodule

// File: rtl/mmu_mem_responder.sv
// Memory-side responder for the cpu RAM bus: MMIO decode for the MMU registers,
// virtual-to-physical translation, page-fault generation and the word memory.
module mmu_mem_responder
  import mmu_pkg::*;
#(
  parameter int unsigned PHYS_AW   = 17,
  parameter logic [15:0] MMIO_BASE = 16'hFF00,
  parameter int unsigned FRAME_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] RAMaddr,
  input  logic [15:0] RAMin,
  input  logic        we,
  input  logic        re,
  input  logic        be,
  output logic [15:0] RAMout,
  output logic        page_fault
);

  localparam int unsigned DEPTH = 1 << (PHYS_AW - 1);

  logic [15:0]        r_mem [DEPTH];
  logic               r_ctrl_en;
  logic [15:0]        r_fault_addr;
  logic               r_fault_lock;

  logic               w_mmio;
  logic [5:0]         w_off;
  logic               w_tvalid;
  logic               w_twritable;
  logic [FRAME_W-1:0] w_tframe;
  logic [15:0]        w_pte_rd;
  logic               w_pte_we;
  logic               w_ctrl_we;
  logic [PHYS_AW-2:0] w_widx;
  logic               w_access;
  logic               w_locked;
  logic               w_fault;
  logic               w_mem_we;
  logic [15:0]        w_mmio_word;
  logic [15:0]        w_word;
  logic [15:0]        w_rd_data;

  assign w_mmio = (RAMaddr[15:6] == MMIO_BASE[15:6]);
  assign w_off  = RAMaddr[5:0];

  // MMIO writes are word-only; byte writes into the window are dropped.
  assign w_pte_we  = we && w_mmio && !be && (w_off[5] == OFF_PTE_BASE[5]);
  assign w_ctrl_we = we && w_mmio && !be && (w_off[5:1] == OFF_CTRL[5:1]);

  mmu_pte_file #(
    .FRAME_W (FRAME_W)
  ) u_pte_file (
    .clk         (clk),
    .reset       (reset),
    .i_we        (w_pte_we),
    .i_widx      (w_off[4:1]),
    .i_wdata     (RAMin),
    .i_tidx      (RAMaddr[15:12]),
    .o_tvalid    (w_tvalid),
    .o_twritable (w_twritable),
    .o_tframe    (w_tframe),
    .i_ridx      (w_off[4:1]),
    .o_rdata     (w_pte_rd)
  );

  assign w_widx = r_ctrl_en ? {w_tframe, RAMaddr[11:1]}
                            : (PHYS_AW-1)'(RAMaddr[15:1]);

  // A held access to the faulting address is swallowed until the cpu idles or moves on.
  assign w_access = re || we;
  assign w_locked = r_fault_lock && w_access && (RAMaddr == r_fault_addr);
  assign w_fault  = r_ctrl_en && !w_mmio && !w_locked &&
                    ((w_access && !w_tvalid) || (we && !w_twritable));
  assign w_mem_we = we && !w_mmio && !w_fault && !w_locked;

  always_comb begin
    w_mmio_word = '0;
    if (w_off[5] == OFF_PTE_BASE[5]) begin
      w_mmio_word = w_pte_rd;
    end else if (w_off[5:1] == OFF_CTRL[5:1]) begin
      w_mmio_word[CTRL_EN] = r_ctrl_en;
    end else if (w_off[5:1] == OFF_FAULT_ADDR[5:1]) begin
      w_mmio_word = r_fault_addr;
    end
  end

  assign w_word    = w_mmio ? w_mmio_word : r_mem[w_widx];
  assign w_rd_data = !be        ? w_word :
                     RAMaddr[0] ? {8'h00, w_word[15:8]} : {8'h00, w_word[7:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RAMout       <= '0;
      page_fault   <= 1'b0;
      r_ctrl_en    <= 1'b0;
      r_fault_addr <= '0;
      r_fault_lock <= 1'b0;
    end else begin
      page_fault   <= w_fault;
      r_fault_lock <= w_fault || w_locked;
      if (w_fault) begin
        r_fault_addr <= RAMaddr;
        RAMout       <= '0;
      end else if (re && !we && !w_locked) begin
        RAMout <= w_rd_data;
      end
      if (w_ctrl_we) begin
        r_ctrl_en <= RAMin[CTRL_EN];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      if (!be) begin
        r_mem[w_widx] <= RAMin;
      end else if (RAMaddr[0]) begin
        r_mem[w_widx][15:8] <= RAMin[7:0];
      end else begin
        r_mem[w_widx][7:0] <= RAMin[7:0];
      end
    end
  end

endmodule

// File: tb/tb_mmu_mem_responder.sv
// Directed bench for mmu_mem_responder: identity and mapped accesses, MMIO
// registers, page faults with lock behaviour, and asynchronous reset.
module tb_mmu_mem_responder;

  logic        clk;
  logic        reset;
  logic [15:0] RAMaddr;
  logic [15:0] RAMin;
  logic        we;
  logic        re;
  logic        be;
  logic [15:0] RAMout;
  logic        page_fault;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  mmu_mem_responder #(
    .PHYS_AW   (17),
    .MMIO_BASE (16'hFF00),
    .FRAME_W   (5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .RAMaddr    (RAMaddr),
    .RAMin      (RAMin),
    .we         (we),
    .re         (re),
    .be         (be),
    .RAMout     (RAMout),
    .page_fault (page_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic acc(input logic [15:0] a, input logic [15:0] d,
                     input logic w, input logic r, input logic b);
    RAMaddr = a; RAMin = d; we = w; re = r; be = b;
    @(posedge clk); #1;
    we = 1'b0; re = 1'b0; be = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    acc(a, d, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [15:0] a);
    acc(a, 16'h0000, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; RAMaddr = '0; RAMin = '0; we = 1'b0; re = 1'b0; be = 1'b0;
    idle(); idle();
    check("reset_ramout", RAMout, 16'h0000);
    check("reset_pf", {15'b0, page_fault}, 16'h0000);
    reset = 1'b0;
    idle();

    rd(16'hFF20);                     check("ctrl_reset", RAMout, 16'h0000);
    rd(16'hFF22);                     check("faddr_reset", RAMout, 16'h0000);

    wr(16'h0100, 16'h1234);
    rd(16'h0100);                     check("id_word_rd", RAMout, 16'h1234);
    acc(16'h0101, 16'h0000, 1'b0, 1'b1, 1'b1);
    check("id_byte_rd_hi", RAMout, 16'h0012);
    acc(16'h0100, 16'h0000, 1'b0, 1'b1, 1'b1);
    check("id_byte_rd_lo", RAMout, 16'h0034);

    acc(16'h0101, 16'h00AB, 1'b1, 1'b0, 1'b1);
    rd(16'h0100);                     check("byte_wr_merge", RAMout, 16'hAB34);

    wr(16'hFF04, 16'hC003);
    wr(16'hFF20, 16'h0001);
    rd(16'hFF04);                     check("pte2_rd", RAMout, 16'hC003);
    rd(16'hFF20);                     check("ctrl_rd", RAMout, 16'h0001);
    acc(16'hFF20, 16'h0000, 1'b1, 1'b0, 1'b1);
    rd(16'hFF20);                     check("mmio_byte_wr_ignored", RAMout, 16'h0001);

    wr(16'h2010, 16'h5555);           check("map_wr_no_pf", {15'b0, page_fault}, 16'h0000);
    rd(16'h2010);                     check("map_rd", RAMout, 16'h5555);
    wr(16'hFF20, 16'h0000);
    rd(16'h3010);                     check("phys_3010", RAMout, 16'h5555);

    wr(16'hFF20, 16'h0001);
    RAMaddr = 16'h5000; re = 1'b1; be = 1'b0; we = 1'b0;
    idle();                           check("hold_pf_c1", {15'b0, page_fault}, 16'h0001);
    idle();                           check("hold_pf_c2", {15'b0, page_fault}, 16'h0000);
    idle();                           check("hold_pf_c3", {15'b0, page_fault}, 16'h0000);
    check("fault_ramout", RAMout, 16'h0000);
    re = 1'b0;
    idle();
    rd(16'hFF22);                     check("faddr_rd", RAMout, 16'h5000);
    wr(16'hFF22, 16'h1111);
    rd(16'hFF22);                     check("faddr_ro", RAMout, 16'h5000);
    rd(16'h5000);                     check("refault_pf", {15'b0, page_fault}, 16'h0001);
    check("refault_ramout", RAMout, 16'h0000);

    wr(16'hFF04, 16'h8003);
    wr(16'h2010, 16'h9999);           check("wprot_pf", {15'b0, page_fault}, 16'h0001);
    idle();
    rd(16'h2010);                     check("wprot_rd", RAMout, 16'h5555);
    check("wprot_rd_no_pf", {15'b0, page_fault}, 16'h0000);
    wr(16'hFF20, 16'h0000);
    rd(16'h3010);                     check("wprot_mem_kept", RAMout, 16'h5555);

    acc(16'h0100, 16'h7777, 1'b1, 1'b1, 1'b0);
    check("we_re_hold", RAMout, 16'h5555);
    rd(16'h0100);                     check("we_re_wrote", RAMout, 16'h7777);

    RAMaddr = 16'h0100; re = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("async_rst_ramout", RAMout, 16'h0000);
    check("async_rst_pf", {15'b0, page_fault}, 16'h0000);
    re = 1'b0;
    idle();
    reset = 1'b0;
    idle();
    rd(16'hFF20);                     check("ctrl_after_rst", RAMout, 16'h0000);
    rd(16'hFF04);                     check("pte_after_rst", RAMout, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
